// File: rtl/adder_pkg.sv
// Shared types and default sizing for the chunked adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } adder_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle between a producer/consumer (master) and the adder (slave).
interface chunked_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, busy
  );

endinterface

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit full adder slice.
module adder_chunk
  import adder_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  // Zero-extend by one bit so the carry-out falls out of the add.
  always_comb begin
    {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  end

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle unsigned adder: CHUNK bits per clock, valid/ready on both sides.
module chunked_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic          clk,
  input  logic          rst,
  chunked_adder_if.slave bus
);

  localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int IDX_W  = $clog2(NCHUNK) + 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $fatal(1, "chunked_adder: WIDTH=%0d must be >= 1 and a multiple of CHUNK=%0d", WIDTH, CHUNK);
  end

  adder_state_t     state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH:0]   res_q, res_d;
  logic             carry_q, carry_d;

  logic [CHUNK-1:0] chunk_x, chunk_y, chunk_s;
  logic             chunk_co;

  // Select the operand slice addressed by the chunk index.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    chunk_x = '0;
    chunk_y = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) begin
        chunk_x = a_q[i*CHUNK +: CHUNK];
        chunk_y = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x  (chunk_x),
    .y  (chunk_y),
    .ci (carry_q),
    .s  (chunk_s),
    .co (chunk_co)
  );

  // Next-state and datapath update for IDLE -> CALC x NCHUNK -> DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    res_d   = res_q;
    carry_d = carry_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;   // the incoming carry seeds the first chunk
          idx_d   = '0;
          res_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        for (int i = 0; i < NCHUNK; i++) begin
          if (idx_q == IDX_W'(i)) begin
            res_d[i*CHUNK +: CHUNK] = chunk_s;
          end
        end
        carry_d = chunk_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(NCHUNK - 1)) begin
          res_d[WIDTH] = chunk_co;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: operands are reset too, so a reset mid-operation leaves no stale data behind.
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end

  // Handshake outputs come straight from state; sum only from the result register.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = res_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench: directed table on 8/4, corner sequences, random sweep on 8/8 and 16/4.
`timescale 1ns/1ps
module tb_chunked_adder;
  import adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_sw;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main instance: WIDTH=8, CHUNK=4 ----------------
  chunked_adder_if #(.WIDTH(8)) bus8 ();
  chunked_adder #(.WIDTH(8), .CHUNK(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic cin, input string nm);
    int n;
    n = 0;
    bus8.a        = a;
    bus8.b        = b;
    bus8.cin      = cin;
    bus8.in_valid = 1'b1;
    while (!bus8.in_ready && n < 20) begin
      tick();
      n++;
    end
    check({nm, "_in_ready"}, 32'(bus8.in_ready), 32'd1);
    tick();
    bus8.in_valid = 1'b0;
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    while (!bus8.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- sweep instances ----------------
  for (genvar g = 0; g < 2; g++) begin : g_sw
    localparam int SW = (g == 0) ? 8 : 16;
    localparam int SC = (g == 0) ? 8 : 4;
    localparam int SN = SW / SC;

    bit done;

    chunked_adder_if #(.WIDTH(SW)) sw_if ();
    chunked_adder #(.WIDTH(SW), .CHUNK(SC)) u_sw (
      .clk (clk),
      .rst (rst_sw),
      .bus (sw_if.slave)
    );

    initial begin : sw_run
      logic [SW-1:0] ra, rb;
      logic          rc;
      logic [SW:0]   ex;
      int            n;
      done            = 1'b0;
      sw_if.in_valid  = 1'b0;
      sw_if.a         = '0;
      sw_if.b         = '0;
      sw_if.cin       = 1'b0;
      sw_if.out_ready = 1'b1;
      @(negedge rst_sw);
      #1;
      for (int i = 0; i < 1000; i++) begin
        ra = SW'($urandom());
        rb = SW'($urandom());
        rc = 1'($urandom_range(0, 1));
        if (i == 0) begin ra = '1; rb = '1; rc = 1'b1; end
        if (i == 1) begin ra = '1; rb = '0; rc = 1'b1; end
        ex = {1'b0, ra} + {1'b0, rb} + {{SW{1'b0}}, rc};
        sw_if.a        = ra;
        sw_if.b        = rb;
        sw_if.cin      = rc;
        sw_if.in_valid = 1'b1;
        n = 0;
        while (!sw_if.in_ready && n < 20) begin
          tick();
          n++;
        end
        tick();
        sw_if.in_valid = 1'b0;
        sw_if.a        = ~ra;
        sw_if.b        = SW'($urandom());
        n = 0;
        while (!sw_if.out_valid && n < 20) begin
          tick();
          n++;
        end
        check($sformatf("sw%0d_latency", g), 32'(n), 32'(SN));
        check($sformatf("sw%0d_sum_%0d", g, i), 32'(sw_if.sum), 32'(ex));
        tick();
      end
      done = 1'b1;
    end
  end

  // ---------------- main stimulus ----------------
  initial begin : main
    int lat;
    int w;

    vecs[0] = '{a: 8'h01, b: 8'h02, cin: 1'b0, exp: 9'h003};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, exp: 9'h100};
    vecs[2] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, exp: 9'h100};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, exp: 9'h1FF};
    vecs[4] = '{a: 8'h00, b: 8'h00, cin: 1'b0, exp: 9'h000};
    vecs[5] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, exp: 9'h010};
    vecs[6] = '{a: 8'h80, b: 8'h80, cin: 1'b0, exp: 9'h100};

    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.cin       = 1'b0;
    bus8.out_ready = 1'b1;
    rst            = 1'b1;
    rst_sw         = 1'b1;

    tick();
    tick();
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_sum",       32'(bus8.sum),       32'd0);
    check("rst_busy",      32'(bus8.busy),      32'd0);
    check("rst_in_ready",  32'(bus8.in_ready),  32'd0);
    rst    = 1'b0;
    rst_sw = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus8.in_ready), 32'd1);

    // Directed table; operands are scrambled after accept to show they are ignored.
    for (int i = 0; i < 7; i++) begin
      accept8(vecs[i].a, vecs[i].b, vecs[i].cin, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_busy", i),     32'(bus8.busy),     32'd1);
      check($sformatf("vec%0d_in_ready", i), 32'(bus8.in_ready), 32'd0);
      bus8.a = ~vecs[i].a;
      bus8.b = 8'($urandom());
      wait_done8(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      check($sformatf("vec%0d_sum", i), 32'(bus8.sum), 32'(vecs[i].exp));
      tick();
      check($sformatf("vec%0d_out_valid_drop", i), 32'(bus8.out_valid), 32'd0);
      check($sformatf("vec%0d_idle_ready", i),     32'(bus8.in_ready),  32'd1);
    end

    // Backpressure: DONE holds for 5 cycles with out_ready low.
    bus8.out_ready = 1'b0;
    accept8(8'h12, 8'h34, 1'b1, "bp");
    bus8.a = 8'hEE;
    bus8.b = 8'hDD;
    wait_done8(lat);
    check("bp_latency", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_hold%0d_valid", k), 32'(bus8.out_valid), 32'd1);
      check($sformatf("bp_hold%0d_sum", k),   32'(bus8.sum),       32'h047);
      check($sformatf("bp_hold%0d_ready", k), 32'(bus8.in_ready),  32'd0);
    end
    bus8.out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(bus8.out_valid), 32'd0);
    check("bp_release_ready", 32'(bus8.in_ready),  32'd1);

    // Reset during the first CALC cycle discards the operation.
    accept8(8'h77, 8'h11, 1'b0, "rst_mid");
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready_comb", 32'(bus8.in_ready), 32'd0);
    tick();
    check("rst_mid_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_mid_sum",       32'(bus8.sum),       32'd0);
    check("rst_mid_in_ready",  32'(bus8.in_ready),  32'd0);
    check("rst_mid_busy",      32'(bus8.busy),      32'd0);
    // Reset and in_valid together: reset wins.
    bus8.a        = 8'h42;
    bus8.b        = 8'h24;
    bus8.in_valid = 1'b1;
    tick();
    check("rst_vs_valid_busy", 32'(bus8.busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rst_no_pulse%0d", k), 32'(bus8.out_valid), 32'd0);
    end
    bus8.in_valid = 1'b0;
    rst           = 1'b0;
    #1;
    check("rst_release_ready", 32'(bus8.in_ready), 32'd1);
    accept8(8'h03, 8'h05, 1'b0, "after_rst");
    wait_done8(lat);
    check("after_rst_latency", 32'(lat), 32'd2);
    check("after_rst_sum",     32'(bus8.sum), 32'h008);
    tick();

    // Wait for the random sweeps to finish, bounded.
    w = 0;
    while (!(g_sw[0].done && g_sw[1].done) && w < 50000) begin
      tick();
      w++;
    end
    check("sweep_done", 32'({g_sw[1].done, g_sw[0].done}), 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Parametrised, multi-cycle unsigned adder. It adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock, and returns a WIDTH+1-bit sum. It uses valid/ready handshakes on both input and output. It replaces the single-shot 4-bit combinational adder in the datapath where wide operands would otherwise break timing, and it adds flow control and backpressure.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; must be ≥ 1.
- CHUNK, 4, bits added per cycle; WIDTH % CHUNK == 0 is required (elaboration-time check, $fatal otherwise).
- NCHUNK (localparam), WIDTH/CHUNK, number of calculation cycles.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operands a, b, cin valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- cin  in  1  carry-in.
- out_valid  out  1  sum is valid.
- out_ready  in  1  consumer accepts the sum.
- sum  out  WIDTH+1  a + b + cin; MSB is the carry-out.
- busy  out  1  high in CALC or DONE.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready, register a, b, cin into operand registers. Clear chunk index idx to 0 and the result register to 0. Go to CALC.
- **CALC**
  - Each cycle, add operand chunk [idx*CHUNK +: CHUNK] of A and B plus the running carry (cin on the first chunk). Write CHUNK result bits into the same slice of the result register and update the running carry. Increment idx.
  - When idx == NCHUNK-1, write the final carry into result[WIDTH] and go to DONE.
- **DONE**
  - out_valid = 1 and sum = result register, held stable until handshake.
  - On out_ready, go to IDLE.
- in_ready = (state == IDLE) && !rst. In DONE, in_ready is 0: no accept in the same cycle as output handshake.
- Operand inputs are ignored outside the accept cycle. Changes during CALC or DONE do not affect the result.
- in_valid while busy is held off by in_ready = 0. The upstream holds its data; nothing is dropped silently.
- Arithmetic is unsigned modulo 2^(WIDTH+1) and cannot overflow. The all-ones case (2^WIDTH - 1) + (2^WIDTH - 1) + 1 = 2^(WIDTH+1) - 1 is exact.
- sum is driven from the result register only. It is not combinational from the inputs.

## Timing
- Reset values:
  - state = IDLE, idx = 0, result = 0, carry = 0.
  - out_valid = 0, sum = 0, busy = 0.
  - in_ready = 0 while rst is high, and 1 in the first cycle after rst deasserts.
- Latency: accept at edge t0. CALC occupies edges t0+1 .. t0+NCHUNK. out_valid is high from edge t0+NCHUNK.
  - Example: WIDTH=8, CHUNK=4 gives out_valid 2 cycles after accept.
  - CHUNK == WIDTH gives out_valid 1 cycle after accept.
- Throughput: one operation per NCHUNK+2 cycles when out_ready is held high (IDLE, NCHUNK×CALC, DONE).
- Backpressure: with out_ready low, DONE persists indefinitely and sum/out_valid stay constant.
- Reset mid-operation (rst in CALC or DONE): the next edge returns all registers to reset values. The partial result is discarded and no out_valid pulse is produced.
- rst and in_valid in the same cycle: reset wins and nothing is accepted.

## Structure
- Package adder_pkg:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} adder_state_t.
  - Default WIDTH/CHUNK constants.
- Sub-module adder_chunk: purely combinational CHUNK-bit full adder (x, y, ci -> s, co), instantiated once inside chunked_adder.
- chunked_adder owns the FSM, the operand and result registers, idx (width $clog2(NCHUNK)+1), and the carry flop.

## Test plan
- WIDTH=8, CHUNK=4; a=1, b=2, cin=0 -> out_valid 2 cycles after accept, sum=3; in_ready=0 while busy.
- a=0xFF, b=0x01, cin=0 -> sum=0x100, carry propagates across the chunk boundary.
- a=0xAA, b=0x55, cin=1 -> sum=0x100. Then a=0xFF, b=0xFF, cin=1 -> sum=0x1FF.
- out_ready held low 5 cycles in DONE -> sum and out_valid unchanged, in_ready=0. Change a/b during CALC -> result unaffected.
- rst asserted during the first CALC cycle -> next cycle out_valid=0, sum=0, in_ready=0. After rst drops, in_ready=1 and a new 3+5 yields 8.
- Parameter sweep CHUNK=8 (1 cycle) and WIDTH=16/CHUNK=4 (4 cycles): 1000 random operands checked against a+b+cin, each with latency exactly NCHUNK cycles.
